commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- Retire stage directly downstream of the reorder buffer (ROB).
- Consumes the ROB head entry, which carries the result plus {regWrite, memWrite, branch, jump, destination}. Writes the register file or issues a store to memory, then pops the ROB.
- On a branch/jump misprediction, issues a PC redirect, trains the branch predictor, and holds a pipeline flush for a fixed number of cycles.
- Single in-order retirement per cycle at most.

Parameters:
- ROB, 2, ROB tag width minus 1 (tag is ROB+1 bits, 8 entries).
- WIDTH, 31, data width minus 1 (32-bit datapath).
- FLUSH_CYCLES, 2, cycles `flush` is held after a redirect (legal range 1..7).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- headValid  in  1  ROB head entry is ready to commit.
- headResult  in  WIDTH+1  result: rd value, store data, or resolved next PC.
- headInfo  in  WIDTH+5  bit 35 = regWrite, 34 = memWrite, 33 = branch, 32 = jump, [31:0] = destination (rd in [4:0], store address, or predicted next PC).
- headTag  in  ROB+1  ROB index of the head entry.
- headPop  out  1  one-cycle pulse; ROB advances its read pointer.
- regWrEn  out  1  register file write strobe.
- regWrAddr  out  5  destination register.
- regWrData  out  WIDTH+1  write data.
- regWrTag  out  ROB+1  tag of the retiring entry, used to clear register-status mapping.
- memReq  out  1  store request; held until acknowledged.
- memAddr  out  WIDTH+1  store address.
- memData  out  WIDTH+1  store data.
- memAck  in  1  memory accepted the store.
- redirectValid  out  1  fetch redirect pulse.
- redirectPC  out  WIDTH+1  correct next PC.
- bpuUpdate  out  1  predictor training pulse.
- bpuMispredict  out  1  qualifies `bpuUpdate`.
- flush  out  1  squash all speculative state (ROB, reservation stations, fetch).

Behaviour:
- Reset (reset = 0, asynchronous): FSM goes to IDLE, flush counter = 0. All outputs 0, including `memReq`, `flush` and `headPop`.
- FSM states: IDLE, STORE_WAIT, FLUSH. All outputs are registered.
- IDLE with headValid = 1 at an edge. Decode priority: memWrite > (branch | jump) > regWrite > none.
  - regWrite: next cycle `regWrEn` = 1 with addr = headInfo[4:0], data = headResult, regWrTag = headTag. `headPop` = 1. Stay in IDLE. Latency: 1 cycle, throughput 1 per cycle.
  - regWrite with rd = 0: pop without asserting `regWrEn`.
  - memWrite: next cycle `memReq` = 1 with memAddr = headInfo[31:0], memData = headResult. Go to STORE_WAIT. No pop yet.
  - branch | jump: `bpuUpdate` = 1 and `headPop` = 1. Mispredict = (headResult != headInfo[31:0]).
    - Mispredict: also `bpuMispredict` = 1, `redirectValid` = 1, redirectPC = headResult, `flush` = 1. Load counter = FLUSH_CYCLES; go to FLUSH.
    - Otherwise: stay in IDLE.
    - jump with regWrite (link) also writes the register file in the same cycle.
  - none of the four bits set: pop only.
- STORE_WAIT:
  - `memReq`, `memAddr` and `memData` are stable until the edge at which memAck = 1.
  - That edge drops `memReq`; the following cycle pulses `headPop`; FSM returns to IDLE.
  - `headValid` is ignored while in STORE_WAIT.
  - `memAck` while `memReq` = 0 is ignored.
- FLUSH: `flush` stays 1 while counter > 0. The counter decrements each cycle; at 0 the FSM returns to IDLE.
  - `headValid` is ignored during FLUSH: the ROB is being emptied, so no commit may occur.
- Pulse outputs (`headPop`, `regWrEn`, `redirectValid`, `bpuUpdate`, `bpuMispredict`) are high exactly one cycle per committed entry.
- Pop timing: the ROB updates on the falling edge, so `headPop` asserted after a rising edge is consumed at the next falling edge. Therefore at most one pop per rising-to-rising period.
- Reset mid-store: `memReq` drops asynchronously and the entry is not popped.
- `headValid` = 0 in IDLE: all pulse outputs are 0.
- Width rules: address and data are taken directly from the WIDTH-bit fields; there is no sign extension.

Optional Feature:
- Macro: COMMIT_PERF_CNT_EN.
- Defined:
  - Add outputs `commitCount` [31:0] and `mispredictCount` [31:0].
  - `commitCount` increments on each `headPop`; `mispredictCount` increments on each `redirectValid`.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset mid-STORE_WAIT with memReq = 1 → memReq = 0 immediately, state IDLE, no headPop.
- Back-to-back register writes: three regWrite entries (rd = 5, 6, 7; data 0x11, 0x22, 0x33) with headValid held high → regWrEn pulses on three consecutive cycles with matching addr/data, and 3 headPops.
- Store with late ack: memWrite entry, addr 0x100, data 0xDEAD; memAck held 0 for 4 cycles → memReq high and addr/data stable for 4+ cycles, headPop exactly one cycle after ack.
- Correct branch: headResult = headInfo[31:0] = 0x40 → bpuUpdate = 1, bpuMispredict = 0, no redirect, no flush.
- Mispredicted branch: predicted 0x40, actual 0x80 → redirectValid = 1, redirectPC = 0x80, flush high for FLUSH_CYCLES + 1 = 3 cycles. A headValid presented during the flush is not popped.
- rd = 0 register write → headPop = 1, regWrEn = 0. With COMMIT_PERF_CNT_EN defined, commitCount increments by 1.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit: ROB retire stage; writes regfile, issues stores, redirects and flushes on mispredict.
// Optional COMMIT_PERF_CNT_EN adds commitCount/mispredictCount outputs.
module commit_unit #(
  parameter int ROB          = 2,
  parameter int WIDTH        = 31,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             headValid,
  input  logic [WIDTH:0]   headResult,
  input  logic [WIDTH+4:0] headInfo,
  input  logic [ROB:0]     headTag,
  output logic             headPop,
  output logic             regWrEn,
  output logic [4:0]       regWrAddr,
  output logic [WIDTH:0]   regWrData,
  output logic [ROB:0]     regWrTag,
  output logic             memReq,
  output logic [WIDTH:0]   memAddr,
  output logic [WIDTH:0]   memData,
  input  logic             memAck,
  output logic             redirectValid,
  output logic [WIDTH:0]   redirectPC,
  output logic             bpuUpdate,
  output logic             bpuMispredict,
  output logic             flush
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [31:0]      commitCount,
  output logic [31:0]      mispredictCount
`endif
);
  typedef enum logic [1:0] {IDLE, STORE_WAIT, FLUSH} state_t;
  state_t state;
  logic [2:0] cnt;
  logic rw, mw, ctl, link, mis, take;
  logic [WIDTH:0] dest;
  always_comb begin
    rw   = headInfo[WIDTH+4];
    mw   = headInfo[WIDTH+3];
    ctl  = headInfo[WIDTH+2] | headInfo[WIDTH+1];
    dest = headInfo[WIDTH:0];
    mis  = ctl && (headResult != dest);
    take = (state == IDLE) && headValid && !mw;
    // only plain register ops and jump-and-link write rd; r0 is never written
    link = rw && (headInfo[4:0] != 5'd0) && (!ctl || headInfo[WIDTH+1]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      headPop       <= 1'b0;
      regWrEn       <= 1'b0;
      regWrAddr     <= 5'd0;
      regWrData     <= '0;
      regWrTag      <= '0;
      memReq        <= 1'b0;
      memAddr       <= '0;
      memData       <= '0;
      redirectValid <= 1'b0;
      redirectPC    <= '0;
      bpuUpdate     <= 1'b0;
      bpuMispredict <= 1'b0;
      flush         <= 1'b0;
    end else begin
      headPop       <= 1'b0;
      regWrEn       <= 1'b0;
      redirectValid <= 1'b0;
      bpuUpdate     <= 1'b0;
      bpuMispredict <= 1'b0;
      case (state)
        IDLE: begin
          if (headValid && mw) begin
            memReq  <= 1'b1;
            memAddr <= dest;
            memData <= headResult;
            state   <= STORE_WAIT;
          end
          if (take) begin
            headPop       <= 1'b1;
            bpuUpdate     <= ctl;
            bpuMispredict <= mis;
            regWrEn       <= link;
            if (link) begin
              regWrAddr <= headInfo[4:0];
              regWrData <= headResult;
              regWrTag  <= headTag;
            end
            if (mis) begin
              redirectValid <= 1'b1;
              redirectPC    <= headResult;
              flush         <= 1'b1;
              cnt           <= 3'(FLUSH_CYCLES);
              state         <= FLUSH;
            end
          end
        end
        STORE_WAIT: begin
          if (memAck) begin
            memReq  <= 1'b0;
            headPop <= 1'b1;
            state   <= IDLE;
          end
        end
        FLUSH: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            flush <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef COMMIT_PERF_CNT_EN
  logic pop_now, mis_now;
  always_comb begin
    pop_now = take || ((state == STORE_WAIT) && memAck);
    mis_now = take && mis;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commitCount     <= 32'd0;
      mispredictCount <= 32'd0;
    end else begin
      commitCount     <= commitCount + 32'(pop_now);
      mispredictCount <= mispredictCount + 32'(mis_now);
    end
  end
`endif
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: vector table, hand sequences and randomized entries checked against a spec-level model.
module tb_commit_unit;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic headValid = 1'b0, memAck = 1'b0;
  logic [31:0] headResult = '0;
  logic [35:0] headInfo = '0;
  logic [2:0] headTag = '0;
  logic headPop, regWrEn, memReq, redirectValid, bpuUpdate, bpuMispredict, flush;
  logic [4:0] regWrAddr;
  logic [31:0] regWrData, memAddr, memData, redirectPC;
  logic [2:0] regWrTag;
`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] commitCount, mispredictCount;
`endif
  int checks = 0, errors = 0, exp_pops = 0, exp_mis = 0;

  commit_unit #(.ROB(2), .WIDTH(31), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .headValid(headValid), .headResult(headResult),
    .headInfo(headInfo), .headTag(headTag), .headPop(headPop), .regWrEn(regWrEn),
    .regWrAddr(regWrAddr), .regWrData(regWrData), .regWrTag(regWrTag), .memReq(memReq),
    .memAddr(memAddr), .memData(memData), .memAck(memAck), .redirectValid(redirectValid),
    .redirectPC(redirectPC), .bpuUpdate(bpuUpdate), .bpuMispredict(bpuMispredict),
    .flush(flush)
`ifdef COMMIT_PERF_CNT_EN
    , .commitCount(commitCount), .mispredictCount(mispredictCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pop, we, mreq, bu, bm, fl;
  } exp_t;
  typedef struct {
    logic [35:0] info;
    logic [31:0] res;
    logic [2:0]  tag;
    exp_t        e;
    int          dly;
  } vec_t;
  vec_t vt[11];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Expected commit reaction derived from the retirement rules
  function automatic exp_t model(input logic [35:0] info, input logic [31:0] res);
    exp_t e;
    bit is_ctl;
    e = '{default: 1'b0};
    is_ctl = info[33] || info[32];
    if (info[34]) begin
      e.mreq = 1'b1;
    end else begin
      e.pop = 1'b1;
      e.bu  = is_ctl;
      e.bm  = is_ctl && (res != info[31:0]);
      e.fl  = e.bm;
      e.we  = info[35] && (info[4:0] != 5'd0) && (!is_ctl || info[32]);
    end
    return e;
  endfunction

  task automatic run_entry(input logic [35:0] info, input logic [31:0] res, input logic [2:0] tag,
                           input exp_t e, input int dly);
    headInfo = info; headResult = res; headTag = tag; headValid = 1'b1;
    tick;
    chk("pop", 64'(headPop), 64'(e.pop));
    chk("reg_wr_en", 64'(regWrEn), 64'(e.we));
    chk("mem_req", 64'(memReq), 64'(e.mreq));
    chk("bpu_update", 64'(bpuUpdate), 64'(e.bu));
    chk("bpu_mispredict", 64'(bpuMispredict), 64'(e.bm));
    chk("redirect_valid", 64'(redirectValid), 64'(e.bm));
    chk("flush", 64'(flush), 64'(e.fl));
    if (e.pop) exp_pops++;
    if (e.bm) exp_mis++;
    if (e.we) begin
      chk("reg_wr_addr", 64'(regWrAddr), 64'(info[4:0]));
      chk("reg_wr_data", 64'(regWrData), 64'(res));
      chk("reg_wr_tag", 64'(regWrTag), 64'(tag));
    end
    if (e.mreq) begin
      chk("mem_addr", 64'(memAddr), 64'(info[31:0]));
      chk("mem_data", 64'(memData), 64'(res));
    end
    if (e.bm) chk("redirect_pc", 64'(redirectPC), 64'(res));
    headValid = 1'b0;
    if (e.mreq) begin
      for (int i = 0; i < dly; i++) begin
        headValid = 1'($urandom_range(0, 1));
        tick;
        chk("store_hold_req", 64'(memReq), 64'd1);
        chk("store_hold_addr", 64'(memAddr), 64'(info[31:0]));
        chk("store_hold_data", 64'(memData), 64'(res));
        chk("store_hold_nopop", 64'(headPop), 64'd0);
      end
      headValid = 1'b0; memAck = 1'b1;
      tick;
      memAck = 1'b0;
      chk("store_ack_req", 64'(memReq), 64'd0);
      chk("store_ack_pop", 64'(headPop), 64'd1);
      exp_pops++;
    end else if (e.fl) begin
      headValid = 1'b1; headInfo = 36'h8_0000_0009; headResult = 32'hBAD;
      for (int i = 0; i < FC; i++) begin
        tick;
        chk("flush_hold", 64'(flush), 64'd1);
        chk("flush_nopop", 64'(headPop), 64'd0);
        chk("flush_nowr", 64'(regWrEn), 64'd0);
      end
      tick;
      chk("flush_end", 64'(flush), 64'd0);
      chk("flush_end_nopop", 64'(headPop), 64'd0);
      headValid = 1'b0;
    end
    memAck = 1'($urandom_range(0, 1));
    tick;
    memAck = 1'b0;
    chk("idle_pop", 64'(headPop), 64'd0);
    chk("idle_mem_req", 64'(memReq), 64'd0);
    chk("idle_pulses", 64'({regWrEn, bpuUpdate, redirectValid, bpuMispredict}), 64'd0);
  endtask

  initial begin
    logic [35:0] info;
    logic [31:0] res, dest;
    vt[0]  = '{36'h8_0000_0005, 32'h11,   3'd1, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, 0};
    vt[1]  = '{36'h4_0000_0100, 32'hDEAD, 3'd2, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 4};
    vt[2]  = '{36'h2_0000_0040, 32'h40,   3'd3, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 0};
    vt[3]  = '{36'h2_0000_0040, 32'h80,   3'd4, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}, 0};
    vt[4]  = '{36'h8_0000_0000, 32'h55,   3'd5, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 0};
    vt[5]  = '{36'h0_0000_0007, 32'h1,    3'd6, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 0};
    vt[6]  = '{36'h9_0000_0201, 32'h201,  3'd7, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 0};
    vt[7]  = '{36'hF_0000_0300, 32'h7,    3'd0, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 0};
    vt[8]  = '{36'hA_0000_0043, 32'h43,   3'd1, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 0};
    vt[9]  = '{36'h9_0000_001F, 32'h400,  3'd2, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, 0};
    vt[10] = '{36'h3_0000_0044, 32'h44,   3'd3, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 1};
    #2 reset = 1'b0;
    #1;
    chk("reset_outputs", 64'({headPop, regWrEn, memReq, redirectValid, bpuUpdate, bpuMispredict, flush}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    // reset during an outstanding store
    headInfo = 36'h4_0000_0100; headResult = 32'hDEAD; headValid = 1'b1;
    tick;
    chk("rst_store_req", 64'(memReq), 64'd1);
    headValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_async_req", 64'(memReq), 64'd0);
    chk("rst_async_pop", 64'(headPop), 64'd0);
    @(negedge clk) reset = 1'b1;
    exp_pops = 0; exp_mis = 0;
    tick;
    chk("rst_no_pop", 64'(headPop), 64'd0);
    run_entry(36'h8_0000_0002, 32'h99, 3'd0, model(36'h8_0000_0002, 32'h99), 0);
    // back-to-back register writes with headValid held
    headValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      headInfo = 36'h8_0000_0000 | 36'(5 + i);
      headResult = 32'(17 * (i + 1));
      headTag = 3'(i);
      tick;
      chk("b2b_wr_en", 64'(regWrEn), 64'd1);
      chk("b2b_addr", 64'(regWrAddr), 64'(5 + i));
      chk("b2b_data", 64'(regWrData), 64'(17 * (i + 1)));
      chk("b2b_pop", 64'(headPop), 64'd1);
      exp_pops++;
    end
    headValid = 1'b0;
    tick;
    chk("b2b_after", 64'({headPop, regWrEn}), 64'd0);
    foreach (vt[k]) run_entry(vt[k].info, vt[k].res, vt[k].tag, vt[k].e, vt[k].dly);
    for (int n = 0; n < 80; n++) begin
      res = $urandom;
      dest = ($urandom_range(0, 1) == 1) ? res : $urandom;
      info = {4'($urandom_range(0, 15)), dest};
      run_entry(info, res, 3'($urandom_range(0, 7)), model(info, res), $urandom_range(0, 5));
    end
`ifdef COMMIT_PERF_CNT_EN
    chk("commit_count", 64'(commitCount), 64'(exp_pops));
    chk("mispredict_count", 64'(mispredictCount), 64'(exp_mis));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
